// File: rtl/lms_pkg.sv
// Shared LMS filter constants and the tap reader state encoding.
// Reused by the tap reader, MAC and weight-update blocks.
package lms_pkg;

    localparam int DATA_W = 16;
    localparam int TAPS   = 16;
    localparam int ADDR_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/lms_sample_buf.sv
// TAPS-deep sample register array: one enabled write port, one combinational
// read port, cleared to zero by a synchronous reset.
module lms_sample_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Wr_en,
    input  logic [ADDR_W-1:0] Wr_addr,
    input  logic [DATA_W-1:0] Wr_data,
    input  logic [ADDR_W-1:0] Rd_addr,
    output logic [DATA_W-1:0] Rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (Wr_en) begin
            mem[Wr_addr] <= Wr_data;
        end
    end

    assign Rd_data = mem[Rd_addr];

endmodule

// File: rtl/lms_tap_reader.sv
// Circular tap-delay buffer with a read sequencer: each accepted sample is
// stored, then the newest TAPS taps are streamed out newest-first.
module lms_tap_reader #(
    parameter int DATA_W = lms_pkg::DATA_W,
    parameter int TAPS   = lms_pkg::TAPS,
    parameter int ADDR_W = lms_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Sample_valid,
    input  logic [DATA_W-1:0] Sample_in,
    output logic              Sample_ready,
    output logic [DATA_W-1:0] Tap_data,
    output logic [ADDR_W-1:0] Tap_index,
    output logic              Tap_valid,
    input  logic              Tap_ready,
    output logic              Tap_last,
    output logic              Busy
);

    import lms_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] tap_index_p1;
    logic [ADDR_W-1:0] next_index;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] tap_data_p1;
    logic [DATA_W-1:0] rd_data;
    logic              tap_last_p1;
    logic              sample_acc;
    logic              tap_hs;

    assign Sample_ready = (state_q == IDLE);
    assign Busy         = (state_q == STREAM);
    assign Tap_valid    = Busy;
    assign sample_acc   = Sample_valid && Sample_ready;
    assign tap_hs       = Tap_valid && Tap_ready;

    // Address of the tap about to be loaded: newest sample sits at base, older ones below it.
    assign next_index = tap_index_p1 + ADDR_W'(1);
    assign rd_addr    = base_q - next_index;

    lms_sample_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (TAPS),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .Clk     (Clk),
        .Reset   (Reset),
        .Wr_en   (sample_acc),
        .Wr_addr (wr_ptr_q),
        .Wr_data (Sample_in),
        .Rd_addr (rd_addr),
        .Rd_data (rd_data)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_acc) state_d = STREAM;
            STREAM:  if (tap_hs && tap_last_p1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tap output stage: k=0 bypasses the buffer, later taps come from the read port.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q     <= '0;
            base_q       <= '0;
            tap_index_p1 <= '0;
            tap_data_p1  <= '0;
            tap_last_p1  <= 1'b0;
        end else if (sample_acc) begin
            wr_ptr_q     <= wr_ptr_q + ADDR_W'(1);
            base_q       <= wr_ptr_q;
            tap_index_p1 <= '0;
            tap_data_p1  <= Sample_in;
            tap_last_p1  <= 1'b0;
        end else if (tap_hs && !tap_last_p1) begin
            tap_index_p1 <= next_index;
            tap_data_p1  <= rd_data;
            tap_last_p1  <= (next_index == ADDR_W'(TAPS - 1));
        end
    end

    assign Tap_data  = tap_data_p1;
    assign Tap_index = tap_index_p1;
    assign Tap_last  = tap_last_p1;

endmodule

// File: tb/tb_lms_tap_reader.sv
// Bench for lms_tap_reader: constant-table bursts, directed corner sequences
// and randomized traffic against a sample-history reference model.
module tb_lms_tap_reader;

    localparam int DATA_W = 16;
    localparam int TAPS   = 16;
    localparam int ADDR_W = 4;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Sample_valid = 1'b0;
    logic [DATA_W-1:0] Sample_in = '0;
    logic              Sample_ready;
    logic [DATA_W-1:0] Tap_data;
    logic [ADDR_W-1:0] Tap_index;
    logic              Tap_valid;
    logic              Tap_ready = 1'b0;
    logic              Tap_last;
    logic              Busy;

    lms_tap_reader #(.DATA_W(DATA_W), .TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Sample_valid (Sample_valid),
        .Sample_in    (Sample_in),
        .Sample_ready (Sample_ready),
        .Tap_data     (Tap_data),
        .Tap_index    (Tap_index),
        .Tap_valid    (Tap_valid),
        .Tap_ready    (Tap_ready),
        .Tap_last     (Tap_last),
        .Busy         (Busy)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: every sample accepted since reset, plus the burst position.
    logic [DATA_W-1:0] hist[$];
    bit                m_stream = 0;
    int                m_k = 0;
    bit                after_rst = 0;
    bit                hs_last = 0;
    logic [DATA_W-1:0] obs [TAPS];

    typedef struct {
        logic [DATA_W-1:0] x;
        int                ka;
        logic [DATA_W-1:0] ea;
        int                kb;
        logic [DATA_W-1:0] eb;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [DATA_W-1:0] ref_tap(input int k);
        int i;
        i = hist.size() - 1 - k;
        return (i >= 0) ? hist[i] : '0;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance model, clock.
    task automatic cyc(input bit rst, input bit sv, input logic [DATA_W-1:0] sin, input bit tr);
        Reset = rst; Sample_valid = sv; Sample_in = sin; Tap_ready = tr;
        chk("sample_ready", 32'(Sample_ready), 32'(!m_stream));
        chk("tap_valid", 32'(Tap_valid), 32'(m_stream));
        chk("busy", 32'(Busy), 32'(m_stream));
        if (after_rst) begin
            chk("rst_tap_data", 32'(Tap_data), 32'h0);
            chk("rst_tap_index", 32'(Tap_index), 32'h0);
            chk("rst_tap_last", 32'(Tap_last), 32'h0);
        end
        if (m_stream) begin
            chk("tap_data", 32'(Tap_data), 32'(ref_tap(m_k)));
            chk("tap_index", 32'(Tap_index), 32'(m_k));
            chk("tap_last", 32'(Tap_last), 32'(m_k == TAPS - 1));
        end
        after_rst = rst;
        hs_last = 0;
        if (rst) begin
            hist.delete();
            m_stream = 0;
            m_k = 0;
        end else if (!m_stream) begin
            if (sv) begin
                hist.push_back(sin);
                m_stream = 1;
                m_k = 0;
            end
        end else if (tr) begin
            obs[m_k] = Tap_data;
            if (m_k == TAPS - 1) begin
                m_stream = 0;
                hs_last = 1;
            end else begin
                m_k++;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic feed(input logic [DATA_W-1:0] x);
        for (int c = 0; c < 200 && m_stream; c++) cyc(0, 0, '0, 1);
        cyc(0, 1, x, 0);
    endtask

    // Runs the current burst to its last handshake; returns the number of STREAM cycles.
    task automatic burst(input int stall_k, input int stall_n, input bit sv,
                         input logic [DATA_W-1:0] sval, output int len);
        int stalled;
        bit tr;
        stalled = 0;
        len = 0;
        for (int c = 0; c < 200; c++) begin
            tr = !(m_k == stall_k && stalled < stall_n);
            if (!tr) stalled++;
            len++;
            cyc(0, sv, sval, tr);
            if (hs_last) return;
        end
        n_chk++;
        $display("FAIL burst_timeout: got no last tap after %0d cycles, required within 200", len);
    endtask

    initial begin
        int len;
        vecs[0] = '{16'h0101, 0, 16'h0101, 15, 16'h0000};
        vecs[1] = '{16'h8000, 0, 16'h8000, 1, 16'h0101};
        vecs[2] = '{16'hFFFF, 0, 16'hFFFF, 1, 16'h8000};
        vecs[3] = '{16'h1234, 2, 16'h8000, 3, 16'h0101};
        vecs[4] = '{16'h0042, 4, 16'h0101, 5, 16'h0000};

        @(posedge Clk);
        #1;
        cyc(1, 0, '0, 0);

        for (int i = 0; i < 5; i++) begin
            feed(vecs[i].x);
            burst(-1, 0, 0, '0, len);
            chk("burst_len", 32'(len), 32'(TAPS));
            chk("vec_tap_a", 32'(obs[vecs[i].ka]), 32'(vecs[i].ea));
            chk("vec_tap_b", 32'(obs[vecs[i].kb]), 32'(vecs[i].eb));
        end

        // Twenty samples wrap the write pointer past the end of the buffer.
        cyc(1, 0, '0, 0);
        for (int s = 1; s <= 20; s++) begin
            feed(DATA_W'(s));
            burst(-1, 0, 0, '0, len);
        end
        for (int k = 0; k < TAPS; k++) chk("wrap_tap", 32'(obs[k]), 32'(20 - k));

        // Back-pressure at k=3 for four cycles stretches the burst by four.
        feed(16'h0777);
        burst(3, 4, 0, '0, len);
        chk("stall_len", 32'(len), 32'(TAPS + 4));

        // A sample held during STREAM is taken the cycle after the last handshake.
        feed(16'h0AAA);
        burst(-1, 0, 1, 16'h0BBB, len);
        cyc(0, 1, 16'h0BBB, 1);
        chk("held_valid", 32'(Tap_valid), 32'h1);
        chk("held_k0", 32'(Tap_data), 32'h0BBB);
        burst(-1, 0, 0, '0, len);
        chk("held_k1", 32'(obs[1]), 32'h0AAA);
        chk("held_k2", 32'(obs[2]), 32'h0777);

        // Reset in the middle of a burst.
        feed(16'h0555);
        for (int c = 0; c < 50 && m_k < 7; c++) cyc(0, 0, '0, 1);
        cyc(1, 0, '0, 1);
        chk("midrst_valid", 32'(Tap_valid), 32'h0);
        chk("midrst_busy", 32'(Busy), 32'h0);
        chk("midrst_ready", 32'(Sample_ready), 32'h1);
        feed(16'h0666);
        burst(-1, 0, 0, '0, len);
        chk("midrst_k0", 32'(obs[0]), 32'h0666);
        for (int k = 1; k < TAPS; k++) chk("midrst_old", 32'(obs[k]), 32'h0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0,
                DATA_W'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
